uart_rx: RTL and testbench

- UART receiver: the receive-side counterpart to the transmit path's parity/serializer chain.
- Oversamples RX_IN, detects the start bit and deserializes Width data bits, LSB first.
- Checks the optional parity bit and the stop bit.
- Presents the received byte with a one-cycle valid pulse, or a one-cycle error flag, to the system controller.

---
 rtl/uart_rx_pkg.sv | 34 +++
 rtl/uart_rx_sampler.sv | 59 +++++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared types and constants for the UART receive path.
// Revision : 1.0
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_OUTPUT = 3'd5
    } rx_state_t;

    localparam int  PRESCALE_8  = 8;
    localparam int  PRESCALE_16 = 16;
    localparam int  PRESCALE_32 = 32;

    // Same encoding as the TX parity calculator
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int legal_prescale(input int p);
        if (p == PRESCALE_16 || p == PRESCALE_32) begin
            return p;
        end
        return PRESCALE_8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Purpose  : Per-bit edge counter with 3-point majority vote around mid-bit.
// Revision : 1.0
// ============================================================================
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_run,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_rx,
    output logic                  o_sampled_bit,
    output logic                  o_sample_done,
    output logic                  o_bit_end
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_bit;
    logic                  r_done;
    logic [PRESCALE_W-1:0] w_half;
    logic                  w_bit_end;

    assign w_half    = i_prescale >> 1;
    assign w_bit_end = (r_cnt == (i_prescale - 1'b1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt  <= '0;
            r_s0   <= 1'b1;
            r_s1   <= 1'b1;
            r_bit  <= 1'b1;
            r_done <= 1'b0;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_bit_end ? '0 : r_cnt + 1'b1;
            r_done <= 1'b0;
            if (r_cnt == (w_half - 1'b1)) r_s0 <= i_rx;
            if (r_cnt == w_half)          r_s1 <= i_rx;
            // Third sample is taken live so the vote is ready at P/2+2
            if (r_cnt == (w_half + 1'b1)) begin
                r_bit  <= (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
                r_done <= 1'b1;
            end
        end
    end

    assign o_sampled_bit = r_bit;
    assign o_sample_done = r_done;
    assign o_bit_end     = w_bit_end;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver FSM, deserializer and parity/stop checking.
// Revision : 1.0
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int Width      = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [Width-1:0]      P_DATA,
    output logic                  Data_Valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error
);

    localparam int BC_W = (Width > 1) ? $clog2(Width) : 1;

    rx_state_t             r_state;
    rx_state_t             w_next;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [BC_W-1:0]       r_bitcnt;
    logic [Width-1:0]      r_shift;
    logic                  r_perr_flag;
    logic                  r_serr_flag;
    logic [Width-1:0]      r_pdata;
    logic                  r_valid;
    logic                  r_perr;
    logic                  r_serr;
    logic                  w_start;
    logic                  w_run;
    logic                  w_bit;
    logic                  w_sample_done;
    logic                  w_bit_end;
    logic                  w_last_bit;

    // Leaving IDLE and a back-to-back start out of OUTPUT behave identically
    assign w_start    = ((r_state == ST_IDLE) || (r_state == ST_OUTPUT)) && !RX_IN;
    assign w_run      = w_start || ((r_state != ST_IDLE) && (r_state != ST_OUTPUT));
    assign w_last_bit = (r_bitcnt == BC_W'(Width - 1));

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .i_run         (w_run),
        .i_prescale    (r_prescale),
        .i_rx          (RX_IN),
        .o_sampled_bit (w_bit),
        .o_sample_done (w_sample_done),
        .o_bit_end     (w_bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!RX_IN) w_next = ST_START;
            ST_START:  if (w_bit_end) w_next = w_bit ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_bit_end && w_last_bit) w_next = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_bit_end) w_next = ST_STOP;
            ST_STOP:   if (w_bit_end) w_next = ST_OUTPUT;
            ST_OUTPUT: w_next = RX_IN ? ST_IDLE : ST_START;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_prescale  <= PRESCALE_W'(PRESCALE_8);
            r_par_en    <= 1'b0;
            r_par_typ   <= PAR_EVEN;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_perr_flag <= 1'b0;
            r_serr_flag <= 1'b0;
            r_pdata     <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_serr      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_serr  <= 1'b0;
            if (w_start) begin
                r_prescale  <= PRESCALE_W'(legal_prescale(int'(Prescale)));
                r_par_en    <= PAR_EN;
                r_par_typ   <= PAR_TYP;
                r_bitcnt    <= '0;
                r_perr_flag <= 1'b0;
                r_serr_flag <= 1'b0;
            end
            case (r_state)
                ST_DATA: begin
                    if (w_sample_done) r_shift <= {w_bit, r_shift[Width-1:1]};
                    if (w_bit_end)     r_bitcnt <= w_last_bit ? '0 : r_bitcnt + 1'b1;
                end
                ST_PARITY: begin
                    if (w_sample_done)
                        r_perr_flag <= w_bit ^ (^r_shift) ^ (r_par_typ == PAR_ODD);
                end
                ST_STOP: begin
                    if (w_sample_done) r_serr_flag <= ~w_bit;
                end
                ST_OUTPUT: begin
                    if (!r_perr_flag && !r_serr_flag) begin
                        r_pdata <= r_shift;
                        r_valid <= 1'b1;
                    end else begin
                        r_perr <= r_perr_flag;
                        r_serr <= r_serr_flag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign P_DATA       = r_pdata;
    assign Data_Valid   = r_valid;
    assign Parity_Error = r_perr;
    assign Stop_Error   = r_serr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard testbench for uart_rx.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Parity_Error;
    logic       Stop_Error;

    uart_rx #(
        .Width      (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error)
    );

    always #5 CLK = ~CLK;

    // kind = {stop_error, parity_error}; 0 means a good word
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       r_exp;
    logic [7:0] last_good = 8'h00;
    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         lat_start = -1;

    always @(posedge CLK) cyc++;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic par_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    task automatic push_ok(input logic [7:0] d);
        sb_q.push_back({2'b00, d});
        last_good = d;
    endtask

    task automatic push_err(input logic [1:0] kind);
        sb_q.push_back({kind, last_good});
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                              input logic pb, input logic sb);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pb, p);
        drive_bit(sb, p);
    endtask

    always @(negedge CLK) begin
        if (RST && (Data_Valid || Parity_Error || Stop_Error)) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_pulse", {Stop_Error, Parity_Error, Data_Valid}, 0);
            end else begin
                r_exp = sb_q.pop_front();
                check_eq("data_valid", Data_Valid, (r_exp.kind == 2'b00) ? 1 : 0);
                check_eq("error_flags", {Stop_Error, Parity_Error}, r_exp.kind);
                check_eq("p_data", P_DATA, r_exp.data);
                if (lat_start >= 0) begin
                    check_eq("latency", cyc - lat_start, 89);
                    lat_start = -1;
                end
            end
        end
    end

    initial begin
        RX_IN    = 1'b1;
        RST      = 1'b0;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = PAR_EVEN;
        repeat (3) @(negedge CLK);
        check_eq("rst_p_data", P_DATA, 0);
        check_eq("rst_valid", Data_Valid, 0);
        check_eq("rst_perr", Parity_Error, 0);
        check_eq("rst_serr", Stop_Error, 0);
        RST = 1'b1;
        idle(4);

        // P=8, even parity, latency checked
        PAR_EN = 1'b1;
        push_ok(8'hA5);
        lat_start = cyc;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
        idle(16);

        // P=16, odd parity: good then bad parity
        Prescale = 6'd16;
        PAR_TYP  = PAR_ODD;
        push_ok(8'hA5);
        send_frame(8'hA5, 16, 1'b1, 1'b1, 1'b1);
        idle(32);
        push_err(2'b01);
        send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b1);
        idle(32);

        // P=8, no parity, bad stop bit: 0x3C must not reach P_DATA
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = PAR_EVEN;
        push_err(2'b10);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        idle(16);

        // Start-bit glitch, then a clean frame
        drive_bit(1'b0, 2);
        idle(20);
        push_ok(8'h5A);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        idle(16);

        // P=32, back-to-back frames, no gap
        Prescale = 6'd32;
        push_ok(8'h55);
        push_ok(8'hAA);
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b1);
        idle(64);

        // Illegal prescale 12 falls back to 8; odd parity
        Prescale = 6'd12;
        PAR_EN   = 1'b1;
        PAR_TYP  = PAR_ODD;
        push_ok(8'h69);
        send_frame(8'h69, 8, 1'b1, par_bit(8'h69, 1'b1), 1'b1);
        idle(16);

        // Reset in the middle of data bit 4
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
        drive_bit(1'b1, 4);
        RST = 1'b0;
        #1;
        check_eq("midrst_p_data", P_DATA, 0);
        check_eq("midrst_valid", Data_Valid, 0);
        check_eq("midrst_errs", {Stop_Error, Parity_Error}, 0);
        last_good = 8'h00;
        idle(3);
        RST = 1'b1;
        idle(4);
        push_ok(8'hFF);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1);
        idle(16);

        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge CLK);
        check_eq("sb_drain", sb_q.size(), 0);
        check_eq("final_p_data", P_DATA, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
